// File: rtl/aes_round_scheduler.sv
// Sequences the shared AES round datapath between the key loader and the USB encrypt path.
// Edge-detects both slow request levels, arbitrates key-first and steps rounds 0..NUM_ROUNDS.
module aes_round_scheduler #(
   parameter int unsigned NUM_ROUNDS = 10
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                key_req,
   input  logic                                data_req,
   input  logic                                core_ready,
   output logic                                load,
   output logic                                op_sel,
   output logic                                round_en,
   output logic [$clog2(NUM_ROUNDS+1)-1:0]     round_num,
   output logic                                key_ack,
   output logic                                data_ack,
   output logic                                key_valid,
   output logic                                busy,
   output logic                                overrun
);

   localparam int unsigned RW = $clog2(NUM_ROUNDS + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_ROUND  = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   state_t          state_q;
   logic [RW-1:0]   cnt_q;
   logic            key_prev_q, data_prev_q;
   logic            key_pend_q, data_pend_q;
   logic            key_valid_q, op_sel_q, load_q, busy_q;
   logic            key_ack_q, data_ack_q, overrun_q;

   logic            key_rise_c, data_rise_c, key_clr_c, data_clr_c, last_round_c;
   logic            key_pend_d, data_pend_d, overrun_d;

   // A rise coinciding with its own FINISH clear re-queues the job instead of flagging overrun.
   always_comb begin
      key_rise_c   = key_req  & ~key_prev_q;
      data_rise_c  = data_req & ~data_prev_q;
      key_clr_c    = (state_q == ST_FINISH) & ~op_sel_q;
      data_clr_c   = (state_q == ST_FINISH) &  op_sel_q;
      key_pend_d   = key_rise_c  | (key_pend_q  & ~key_clr_c);
      data_pend_d  = data_rise_c | (data_pend_q & ~data_clr_c);
      overrun_d    = (key_rise_c  & key_pend_q  & ~key_clr_c) |
                     (data_rise_c & data_pend_q & ~data_clr_c);
      last_round_c = (cnt_q == RW'(NUM_ROUNDS));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         key_prev_q  <= 1'b0;
         data_prev_q <= 1'b0;
         key_pend_q  <= 1'b0;
         data_pend_q <= 1'b0;
         key_valid_q <= 1'b0;
         op_sel_q    <= 1'b0;
         load_q      <= 1'b0;
         busy_q      <= 1'b0;
         key_ack_q   <= 1'b0;
         data_ack_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         key_prev_q  <= key_req;
         data_prev_q <= data_req;
         key_pend_q  <= key_pend_d;
         data_pend_q <= data_pend_d;
         overrun_q   <= overrun_d;
         load_q      <= 1'b0;
         key_ack_q   <= 1'b0;
         data_ack_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // Key jobs win; an encrypt job waits until an expanded key exists.
               if (key_pend_q) begin
                  state_q     <= ST_LOAD;
                  op_sel_q    <= 1'b0;
                  load_q      <= 1'b1;
                  busy_q      <= 1'b1;
                  cnt_q       <= '0;
                  key_valid_q <= 1'b0;
               end else if (data_pend_q && key_valid_q) begin
                  state_q  <= ST_LOAD;
                  op_sel_q <= 1'b1;
                  load_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  cnt_q    <= '0;
               end
            end
            ST_LOAD: state_q <= ST_ROUND;
            ST_ROUND: begin
               if (core_ready) begin
                  if (last_round_c) begin
                     state_q    <= ST_FINISH;
                     key_ack_q  <= ~op_sel_q;
                     data_ack_q <=  op_sel_q;
                  end else begin
                     cnt_q <= cnt_q + RW'(1);
                  end
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!op_sel_q) key_valid_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Round pulse follows the core's same-cycle ready so a stall costs exactly one cycle.
   assign round_en  = (state_q == ST_ROUND) & core_ready;
   assign round_num = cnt_q;
   assign load      = load_q;
   assign op_sel    = op_sel_q;
   assign key_ack   = key_ack_q;
   assign data_ack  = data_ack_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_aes_round_scheduler.sv
// Bench for aes_round_scheduler: job-level reference model compared every cycle,
// directed latency scenarios with literal expectations, then randomized traffic.
module tb_aes_round_scheduler;

   localparam int unsigned NR = 10;
   localparam int unsigned RW = $clog2(NR + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          key_req = 1'b0;
   logic          data_req = 1'b0;
   logic          core_ready = 1'b1;
   logic          load, op_sel, round_en, key_ack, data_ack, key_valid, busy, overrun;
   logic [RW-1:0] round_num;

   always #5 clk = ~clk;

   aes_round_scheduler #(.NUM_ROUNDS(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .key_req    (key_req),
      .data_req   (data_req),
      .core_ready (core_ready),
      .load       (load),
      .op_sel     (op_sel),
      .round_en   (round_en),
      .round_num  (round_num),
      .key_ack    (key_ack),
      .data_ack   (data_ack),
      .key_valid  (key_valid),
      .busy       (busy),
      .overrun    (overrun)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // Job-level model: a job is "active" from its load cycle through its ack cycle.
   bit m_kprev, m_dprev, m_kpend, m_dpend, m_kv, m_active, m_op, m_ovr, m_rst_last;
   int m_age, m_issued;

   always @(posedge clk) begin : model
      bit kr, dr, kclr, dclr, okp, odp, ack_now;
      if (rst) begin
         m_kprev = 0; m_dprev = 0; m_kpend = 0; m_dpend = 0; m_kv = 0;
         m_active = 0; m_op = 0; m_ovr = 0; m_age = 0; m_issued = 0;
         m_rst_last = 1;
      end else begin
         m_rst_last = 0;
         kr      = key_req  && !m_kprev;
         dr      = data_req && !m_dprev;
         ack_now = m_active && (m_issued == NR + 1);
         kclr    = ack_now && !m_op;
         dclr    = ack_now &&  m_op;
         okp     = m_kpend;
         odp     = m_dpend;
         m_ovr   = (kr && okp && !kclr) || (dr && odp && !dclr);
         m_kpend = kr || (okp && !kclr);
         m_dpend = dr || (odp && !dclr);
         m_kprev = key_req;
         m_dprev = data_req;
         if (!m_active) begin
            if (okp) begin
               m_active = 1; m_op = 0; m_age = 0; m_issued = 0; m_kv = 0;
            end else if (odp && m_kv) begin
               m_active = 1; m_op = 1; m_age = 0; m_issued = 0;
            end
         end else if (m_age == 0) begin
            m_age = 1;
         end else if (m_issued <= NR) begin
            if (core_ready) m_issued++;
         end else begin
            m_active = 0;
            if (!m_op) m_kv = 1;
         end
      end
   end

   int n_load = 0, n_ren = 0, n_dack = 0, n_ovr = 0;
   int last_load = 0, first_r0 = 0, last_r4 = 0, last_r6 = 0;
   int last_kack = 0, last_dack = 0, kv_rise = 0;
   bit kv_prev = 0;

   // Per-cycle compare against the model plus event stamps for the directed checks.
   always @(negedge clk) begin : compare
      bit e_load, e_rph, e_ren, e_ack;
      if (chk_en) begin
         e_load = m_active && (m_age == 0);
         e_rph  = m_active && (m_age == 1) && (m_issued <= NR);
         e_ren  = e_rph && core_ready;
         e_ack  = m_active && (m_issued == NR + 1);
         check("load",      32'(load),      32'(e_load));
         check("round_en",  32'(round_en),  32'(e_ren));
         check("key_ack",   32'(key_ack),   32'(e_ack && !m_op));
         check("data_ack",  32'(data_ack),  32'(e_ack && m_op));
         check("key_valid", 32'(key_valid), 32'(m_kv));
         check("busy",      32'(busy),      32'(m_active));
         check("overrun",   32'(overrun),   32'(m_ovr));
         if (e_ren) check("round_num", 32'(round_num), 32'(m_issued));
         if (e_load || e_rph) check("op_sel", 32'(op_sel), 32'(m_op));
         if (m_rst_last) begin
            check("rst_op_sel",    32'(op_sel),    32'd0);
            check("rst_round_num", 32'(round_num), 32'd0);
         end
      end
      if (load === 1'b1) begin n_load++; last_load = cyc; end
      if (round_en === 1'b1) begin
         n_ren++;
         if (round_num == 0) first_r0 = cyc;
         if (round_num == 4) last_r4 = cyc;
         if (round_num == 6) last_r6 = cyc;
      end
      if (key_ack === 1'b1) last_kack = cyc;
      if (data_ack === 1'b1) begin n_dack++; last_dack = cyc; end
      if (overrun === 1'b1) n_ovr++;
      if (key_valid === 1'b1 && !kv_prev) kv_rise = cyc;
      kv_prev = (key_valid === 1'b1);
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int stamp(input int which);
      case (which)
         0:       return last_kack;
         1:       return last_dack;
         2:       return last_r4;
         default: return last_r6;
      endcase
   endfunction

   task automatic wait_stamp(input string nm, input int which, input int base, input int maxc);
      for (int i = 0; i < maxc; i++) begin
         if (stamp(which) > base) break;
         tick(1);
      end
      check({nm, "_wait"}, 32'(stamp(which) > base), 32'd1);
   endtask

   initial begin : stim
      int r, c0, c1;
      tick(1);
      chk_en = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);

      // Key job then encrypt job, core always ready.
      r = cyc; c0 = n_ren; key_req = 1'b1;
      wait_stamp("s1_kack", 0, r, 40);
      check("s1_load_lat",    32'(last_load - r), 32'd2);
      check("s1_first_round", 32'(first_r0 - r),  32'd3);
      check("s1_round_count", 32'(n_ren - c0),    32'd11);
      check("s1_kack_lat",    32'(last_kack - r), 32'd14);
      tick(2);
      check("s1_kv_rise",     32'(kv_rise - r),   32'd15);
      key_req = 1'b0;
      tick(2);
      r = cyc; data_req = 1'b1;
      wait_stamp("s1_dack", 1, r, 40);
      check("s1_dack_lat", 32'(last_dack - r), 32'd14);
      data_req = 1'b0;
      tick(3);

      // Encrypt request before any key exists is held until a key job completes.
      rst = 1'b1; tick(2); rst = 1'b0; tick(2);
      r = cyc; c0 = n_load; data_req = 1'b1;
      tick(20);
      check("s2_no_load", 32'(n_load - c0), 32'd0);
      key_req = 1'b1;
      wait_stamp("s2_kack", 0, r, 40);
      wait_stamp("s2_dack", 1, r, 40);
      check("s2_ack_gap", 32'(last_dack - last_kack), 32'd14);
      key_req = 1'b0; data_req = 1'b0;
      tick(3);

      // Simultaneous requests with a valid key: key job first.
      r = cyc; key_req = 1'b1; data_req = 1'b1;
      wait_stamp("s3_dack", 1, r, 60);
      check("s3_kack_lat", 32'(last_kack - r), 32'd14);
      check("s3_dack_lat", 32'(last_dack - r), 32'd28);
      key_req = 1'b0; data_req = 1'b0;
      tick(3);

      // Three-cycle core stall after round 4.
      r = cyc; c0 = n_ren; key_req = 1'b1;
      wait_stamp("s4_r4", 2, r, 30);
      core_ready = 1'b0;
      tick(3);
      core_ready = 1'b1;
      wait_stamp("s4_kack", 0, r, 40);
      check("s4_kack_lat",    32'(last_kack - r), 32'd17);
      check("s4_round_count", 32'(n_ren - c0),    32'd11);
      key_req = 1'b0;
      tick(3);

      // Second data edge while pending: one overrun, one ack.
      r = cyc; c0 = n_dack; c1 = n_ovr; data_req = 1'b1;
      tick(3); data_req = 1'b0; tick(2); data_req = 1'b1;
      wait_stamp("s5_dack", 1, r, 40);
      check("s5_dack_lat", 32'(last_dack - r), 32'd14);
      tick(4);
      check("s5_one_dack", 32'(n_dack - c0), 32'd1);
      check("s5_overrun",  32'(n_ovr - c1),  32'd1);
      data_req = 1'b0;
      tick(3);

      // Reset in the middle of an encrypt job loses the job and the key.
      r = cyc; c0 = n_dack; data_req = 1'b1;
      wait_stamp("s6_r6", 3, r, 30);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(25);
      check("s6_no_ack",  32'(n_dack - c0),  32'd0);
      check("s6_kv_lost", 32'(key_valid),    32'd0);
      data_req = 1'b0;
      tick(2);

      // Randomized slow levels, ready gaps and occasional reset.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(39, 0) == 0) key_req  = ~key_req;
         if ($urandom_range(24, 0) == 0) data_req = ~data_req;
         core_ready = ($urandom_range(3, 0) != 0);
         rst        = ($urandom_range(599, 0) == 0);
         tick(1);
      end
      rst = 1'b0;
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_round_scheduler.md
# aes_round_scheduler

Controller that sequences the shared AES round datapath between two requesters: the key loader (key expansion jobs) and the USB new-data path (block encryption jobs). It converts each requester's slow level enable into a one-cycle job request, arbitrates, then steps the core through round 0..NUM_ROUNDS with a ready/enable handshake and returns a done pulse to the owner. It sits between the USB receive/key-load logic and the AES core.

## Interface
- NUM_ROUNDS, default 10, index of the final round; the core receives NUM_ROUNDS+1 round pulses (0..NUM_ROUNDS).
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_req  in  1  slow level enable from key loader; each rising edge requests one key-expansion job.
- data_req  in  1  slow level enable from the USB new-data path; each rising edge requests one encrypt job.
- core_ready  in  1  core can accept a round pulse this cycle.
- load  out  1  one-cycle pulse: core latches key/block input for the granted job.
- op_sel  out  1  0 = key expansion, 1 = encrypt; valid from load through final round_en.
- round_en  out  1  one-cycle round step to the core.
- round_num  out  $clog2(NUM_ROUNDS+1)  current round index, valid when round_en=1.
- key_ack  out  1  one-cycle pulse: key job finished.
- data_ack  out  1  one-cycle pulse: encrypt job finished.
- key_valid  out  1  level: an expanded key is available.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  one-cycle pulse: request edge arrived while that requester already had a job pending.

## Operation
- Edge detect per input: registered previous level, reset to 0; rise = level & ~prev. A level already high when rst deasserts produces one request.
- Pending flags key_pend, data_pend: set on rise, cleared in FINISH for the owner. Rise in the same cycle as its own FINISH clear: flag stays set, no overrun. Rise while flag set and not being cleared: overrun=1, flag unchanged (no double queuing).
- States: IDLE, LOAD, ROUND, FINISH.
- IDLE: key_pend -> grant key (fixed priority, key over data). Else data_pend & key_valid -> grant data. Else stay. data_pend with key_valid=0 is held, not dropped.
- LOAD: load=1, op_sel latched, round counter = 0; granting a key job clears key_valid this cycle. -> ROUND.
- ROUND: round_en = core_ready; when core_ready=1 issue round_num = counter and increment. core_ready=0 stalls: round_en=0, counter held, no timeout. Pulse with counter = NUM_ROUNDS -> FINISH.
- FINISH: owner's ack=1, owner's pending cleared; key job sets key_valid (visible next cycle). -> IDLE.
- Key request during an encrypt job: stays pending; the encrypt job completes with the old key, then the key job runs.
- Counter never exceeds NUM_ROUNDS; no wrap.

## Timing
- Reset values: state IDLE, load 0, op_sel 0, round_en 0, round_num 0, key_ack 0, data_ack 0, key_valid 0, busy 0, overrun 0, pending flags 0, prev-level regs 0.
- Input rise sampled at cycle t -> pending visible t+1 -> load at t+2 -> round 0 at t+3 (core_ready=1) -> round NUM_ROUNDS at t+3+NUM_ROUNDS -> ack at t+4+NUM_ROUNDS -> IDLE at t+5+NUM_ROUNDS. Each core_ready=0 cycle in ROUND adds one cycle.
- Minimum spacing between back-to-back jobs: load pulses NUM_ROUNDS+4 cycles apart.
- load, round_en, acks and overrun are single-cycle; round_en never asserts outside ROUND.
- rst mid-job: all outputs to reset values next cycle, pending jobs and key_valid lost, no ack issued.

## Test plan
- Key then data, core_ready=1, NUM_ROUNDS=10: key_req rises cycle 0 -> load cycle 2 op_sel=0, round_en cycles 3..13 with round_num 0..10, key_ack cycle 14, key_valid=1 from cycle 15; data_req rise then gives data_ack 14 cycles after its edge.
- Data before key: data_req rises with key_valid=0 -> no load; key_req rises later -> key job runs, then data job starts; data_ack follows key_ack by exactly 14 cycles.
- Simultaneous key_req and data_req rises with key_valid=1 -> key job granted first, key_valid drops at its load, data job follows.
- core_ready low 3 cycles after round 4 -> round_num 5 held until ready returns, ack delayed by 3 cycles, exactly 11 round_en pulses.
- Second data_req edge while data_pend set -> overrun pulse, only one data_ack; rst asserted at round 6 -> all outputs 0 next cycle, no ack, key_valid=0.
